sram22_req_ctrl: RTL and testbench

- Valid/ready front-end placed directly upstream of the 128x24 byte-masked SRAM macro; it drives the macro's ce/we/wmask/addr/din pins and consumes its dout.
- Registers every request onto the macro pins, tracks reads in flight and buffers read data in a small response FIFO, so consumer backpressure never loses data.
- Writes produce no response.

---
 rtl/sram22_ctrl_pkg.sv | 15 +
 rtl/sram22_rsp_fifo.sv | 44 ++++
 rtl/sram22_req_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram22_req_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram22_ctrl_pkg.sv
// Shared constants and state type for the sram22 request controller.
package sram22_ctrl_pkg;

  localparam int ADDR_WIDTH  = 7;
  localparam int DATA_WIDTH  = 24;
  localparam int WMASK_WIDTH = 3;
  localparam int RAM_DEPTH   = 128;
  localparam int RSP_DEPTH   = 4;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Read-response FIFO: push/pop/count with the head entry presented from storage
// registers. The caller only pops a non-empty FIFO and never pushes a full one.
module sram22_rsp_fifo #(
  parameter  int RSP_DEPTH  = 4,
  parameter  int DATA_WIDTH = 24,
  localparam int PW         = $clog2(RSP_DEPTH),
  localparam int CW         = $clog2(RSP_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CW-1:0]         count,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/sram22_req_ctrl.sv
// Valid/ready front-end for the 128x24 byte-masked SRAM macro. Requests are
// registered onto the macro pins; reads are tracked through the two-cycle macro
// pipeline and land in a response FIFO. req_ready is a registered credit check
// so a full FIFO plus reads in flight can never overflow.
// Optional: define SRAM22_REQ_CTRL_ZERO_INIT_EN to zero the whole array after
// reset (INIT sweep) and expose init_done.
module sram22_req_ctrl #(
  parameter int ADDR_WIDTH  = sram22_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH  = sram22_ctrl_pkg::DATA_WIDTH,
  parameter int WMASK_WIDTH = sram22_ctrl_pkg::WMASK_WIDTH,
  parameter int RSP_DEPTH   = sram22_ctrl_pkg::RSP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
  ,
  output logic                   init_done
`endif
);

  import sram22_ctrl_pkg::*;

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic          accept;
  logic          accept_rd;
  logic          pop;
  logic          rd_s1;
  logic          rd_s2;
  logic [1:0]    inflight_next;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic          credit_ok;
  logic          ready_next;

`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
  state_t                state;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  run_next;

  assign init_done = (state == ST_RUN);
`endif

  assign accept    = req_valid && req_ready;
  assign accept_rd = accept && !req_we;
  assign pop       = rsp_valid && rsp_ready;

  // Credit check on post-edge occupancy so the registered req_ready is exact.
  always_comb begin
    inflight_next = 2'(accept_rd) + 2'(rd_s1);
    count_next    = fifo_count + CW'(rd_s2) - CW'(pop);
    credit_ok     = (int'(count_next) + int'(inflight_next)) < RSP_DEPTH;
`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
    run_next      = (state == ST_RUN) || (init_addr == ADDR_WIDTH'(RAM_DEPTH - 1));
    ready_next    = run_next && credit_ok;
`else
    ready_next    = credit_ok;
`endif
  end

  // Controller FSM and registered macro pins; addr/din hold when idle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      req_ready  <= 1'b0;
`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
      state      <= ST_INIT;
      init_addr  <= '0;
`endif
    end else begin
      req_ready <= ready_next;
`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
      if (state == ST_INIT) begin
        sram_ce    <= 1'b1;
        sram_we    <= 1'b1;
        sram_wmask <= '1;
        sram_addr  <= init_addr;
        sram_din   <= '0;
        init_addr  <= init_addr + ADDR_WIDTH'(1);
        if (init_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) state <= ST_RUN;
      end else
`endif
      if (accept) begin
        sram_ce    <= 1'b1;
        sram_we    <= req_we;
        sram_wmask <= req_wmask;
        sram_addr  <= req_addr;
        sram_din   <= req_wdata;
      end else begin
        sram_ce    <= 1'b0;
        sram_we    <= 1'b0;
        sram_wmask <= '0;
      end
    end
  end

  // Read pipeline: rd_s1 = pins carry a read, rd_s2 = macro dout holds it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_s1 <= 1'b0;
      rd_s2 <= 1'b0;
    end else begin
      rd_s1 <= accept_rd;
      rd_s2 <= rd_s1;
    end
  end

  sram22_rsp_fifo #(
    .RSP_DEPTH (RSP_DEPTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (rd_s2),
    .push_data (sram_dout),
    .pop       (pop),
    .count     (fifo_count),
    .head_valid(rsp_valid),
    .head_data (rsp_rdata)
  );

endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Bench for sram22_req_ctrl with a behavioural model of the SRAM macro.
// Reads push their expected data into a queue; a monitor pops and compares
// whenever a response is consumed.
module tb_sram22_req_ctrl;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_wmask = '0;
  logic [6:0]  req_addr = '0;
  logic [23:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [23:0] rsp_rdata;
  logic        sram_ce, sram_we;
  logic [2:0]  sram_wmask;
  logic [6:0]  sram_addr;
  logic [23:0] sram_din;
  logic [23:0] sram_dout = '0;
`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
  logic        init_done;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_count = 0;
  logic driver_done = 1'b0;
  logic [23:0] exp_q [$];
  logic [23:0] mem [128];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sram22_req_ctrl dut (
    .clk       (clk),
    .rstb      (rstb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wmask (req_wmask),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .sram_ce   (sram_ce),
    .sram_we   (sram_we),
    .sram_wmask(sram_wmask),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
    ,
    .init_done (init_done)
`endif
  );

  function automatic logic [23:0] init_val(input logic [6:0] a);
`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
    return 24'h000000;
`else
    return {8'hC0, 1'b0, a, 8'h3C};
`endif
  endfunction

  // Behavioural macro: byte-masked write, read data valid after the edge.
  initial for (int i = 0; i < 128; i++) mem[i] = {8'hC0, 1'b0, 7'(i), 8'h3C};
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 3; b++)
          if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rstb && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_rdata), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (dut.fifo_count > 3'd4) begin
      total++;
      bad++;
      $display("FAIL fifo_overflow: got %0d expected <=4", dut.fifo_count);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Present a request, wait (bounded) for acceptance, return #1 after the edge.
  task automatic issue(input logic we, input logic [2:0] m, input logic [6:0] a,
                       input logic [23:0] d, input logic [23:0] exp);
    req_valid = 1'b1; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (!we) exp_q.push_back(exp);
    @(posedge clk); #1;
    acc_count++;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rstb = 1'b0; req_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    check("rst_ce", 32'(sram_ce), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk); rstb = 1'b1;
`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
    begin
      int k;
      for (k = 1; k <= 300; k++) begin
        @(posedge clk); #1;
        if (k == 1) check("init_first_addr", 32'(sram_addr), 0);
        if (init_done) break;
      end
      check("init_done_cycles", k, 128);
    end
`else
    @(posedge clk); #1;
`endif
    check("ready_after_rst", 32'(req_ready), 1);
  endtask

  initial begin
    int c0;
    #1;
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_din", 32'(sram_din), 0);
    check("rst_wmask", 32'(sram_wmask), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);

`ifdef SRAM22_REQ_CTRL_ZERO_INIT_EN
    // Interrupt the sweep at address 60; it must restart from 0.
    @(negedge clk); rstb = 1'b1;
    repeat (61) @(posedge clk);
    #1;
    check("init_mid_addr", 32'(sram_addr), 60);
    check("init_mid_done", 32'(init_done), 0);
`endif
    do_reset();

    // Full write then read of addr 5 with pin and latency checks.
    issue(1'b1, 3'b111, 7'd5, 24'hA5B6C7, 24'h0);
    check("wr_ce", 32'(sram_ce), 1);
    check("wr_we", 32'(sram_we), 1);
    check("wr_wmask", 32'(sram_wmask), 3'b111);
    check("wr_addr", 32'(sram_addr), 5);
    check("wr_din", 32'(sram_din), 32'hA5B6C7);
    @(posedge clk); #1;
    check("idle_ce", 32'(sram_ce), 0);
    check("idle_we", 32'(sram_we), 0);
    check("idle_wmask", 32'(sram_wmask), 0);
    check("idle_addr_hold", 32'(sram_addr), 5);
    issue(1'b0, 3'b000, 7'd5, 24'h0, 24'hA5B6C7);
    check("rd_ce", 32'(sram_ce), 1);
    check("rd_we", 32'(sram_we), 0);
    check("rd_lat0", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    check("rd_lat1", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    check("rd_lat2_valid", 32'(rsp_valid), 1);
    check("rd_lat2_data", 32'(rsp_rdata), 32'hA5B6C7);
    wait_drain("drain_first");

    // Partial write over lane 1, then a zero-mask write that changes nothing.
    issue(1'b1, 3'b010, 7'd5, 24'h00FF00, 24'h0);
    issue(1'b0, 3'b000, 7'd5, 24'h0, 24'hA5FFC7);
    issue(1'b1, 3'b000, 7'd5, 24'hFFFFFF, 24'h0);
    check("wm0_ce", 32'(sram_ce), 1);
    check("wm0_we", 32'(sram_we), 1);
    check("wm0_wmask", 32'(sram_wmask), 0);
    issue(1'b0, 3'b000, 7'd5, 24'h0, 24'hA5FFC7);

    // Read-after-write in consecutive cycles.
    issue(1'b1, 3'b111, 7'd9, 24'h123456, 24'h0);
    issue(1'b0, 3'b000, 7'd9, 24'h0, 24'h123456);
    issue(1'b0, 3'b000, 7'd127, 24'h0, init_val(7'd127));
    wait_drain("drain_partial");

    // Backpressure: only four reads fit until the consumer drains.
    rsp_ready = 1'b0;
    acc_count = 0;
    driver_done = 1'b0;
    fork
      begin
        for (int a = 0; a < 10; a++)
          issue(1'b0, 3'b000, 7'(a), 24'h0,
                (a == 5) ? 24'hA5FFC7 : (a == 9) ? 24'h123456 : init_val(7'(a)));
        driver_done = 1'b1;
      end
    join_none
    repeat (12) @(posedge clk);
    #1;
    check("bp_accepted", acc_count, 4);
    check("bp_ready_low", 32'(req_ready), 0);
    rsp_ready = 1'b1;
    for (int n = 0; n < 200 && !driver_done; n++) @(posedge clk);
    #1;
    check("bp_driver_done", 32'(driver_done), 1);
    check("bp_all_accepted", acc_count, 10);
    wait_drain("drain_bp");

    // Back-to-back reads at one per cycle.
    c0 = cyc;
    for (int a = 30; a < 38; a++) issue(1'b0, 3'b000, 7'(a), 24'h0, init_val(7'(a)));
    check("throughput_cycles", cyc - c0, 8);
    wait_drain("drain_tput");

    // Reset with two reads in flight and two responses buffered.
    rsp_ready = 1'b0;
    for (int a = 40; a < 44; a++) issue(1'b0, 3'b000, 7'(a), 24'h0, init_val(7'(a)));
    check("mid_fifo_count", 32'(dut.fifo_count), 2);
    rstb = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_ce", 32'(sram_ce), 0);
    check("mrst_addr", 32'(sram_addr), 0);
    check("mrst_din", 32'(sram_din), 0);
    check("mrst_rsp_valid", 32'(rsp_valid), 0);
    check("mrst_rdata", 32'(rsp_rdata), 0);
    check("mrst_ready", 32'(req_ready), 0);
    @(posedge clk); @(negedge clk);
    rstb = 1'b1;
    rsp_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      check("no_stale_rsp", 32'(rsp_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
